// File: rtl/warp_fetch_scheduler.sv
// Per-warp fetch scheduler: round-robin issue of READY warps to the icache, at most one fetch in flight per warp.
// Fetch outputs follow registered state (a launch is visible next cycle); a stalled grant is locked until ic_ready_i. Optional counter: WARP_FETCH_PERF_COUNTER_EN.
module warp_fetch_scheduler #(
  parameter int PcWidth   = 32,
  parameter int NumWarps  = 8,
  parameter int WarpWidth = 32,
  parameter int WidWidth  = $clog2(NumWarps)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 launch_valid_i,
  output logic                 launch_ready_o,
  input  logic [PcWidth-1:0]   launch_pc_i,
  input  logic [WarpWidth-1:0] launch_act_mask_i,
  input  logic                 ic_ready_i,
  output logic                 fe_valid_o,
  output logic [PcWidth-1:0]   fe_pc_o,
  output logic [WarpWidth-1:0] fe_act_mask_o,
  output logic [WidWidth-1:0]  fe_warp_id_o,
  input  logic                 dec_decoded_i,
  input  logic                 dec_stop_warp_i,
  input  logic [WidWidth-1:0]  dec_decoded_warp_id_i,
  input  logic [PcWidth-1:0]   dec_decoded_next_pc_i,
  output logic                 busy_o,
  output logic [31:0]          fetch_count_o
);

  typedef enum logic [1:0] {
    ST_INACTIVE = 2'd0,
    ST_READY    = 2'd1,
    ST_WAITING  = 2'd2
  } warp_state_e;

  warp_state_e          r_state [NumWarps];
  logic [PcWidth-1:0]   r_pc    [NumWarps];
  logic [WarpWidth-1:0] r_mask  [NumWarps];
  logic [WidWidth-1:0]  r_last;
  logic [WidWidth-1:0]  r_lock_id;
  logic                 r_lock;

  logic [NumWarps-1:0]  w_ready;
  logic [NumWarps-1:0]  w_inactive;
  logic [WidWidth-1:0]  w_probe;
  logic [WidWidth-1:0]  w_rr_id;
  logic                 w_rr_found;
  logic [WidWidth-1:0]  w_free_id;
  logic [WidWidth-1:0]  w_sel_id;
  logic                 w_fire;
  logic                 w_launch;
  logic                 w_dec;

  always_comb begin
    w_ready    = '0;
    w_inactive = '0;
    for (int i = 0; i < NumWarps; i++) begin
      w_ready[i]    = (r_state[i] == ST_READY);
      w_inactive[i] = (r_state[i] == ST_INACTIVE);
    end
  end

  // Round-robin search starts just after the last granted warp; the index wraps by width.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_id    = '0;
    w_probe    = '0;
    for (int k = 1; k <= NumWarps; k++) begin
      w_probe = r_last + WidWidth'(k);
      if (!w_rr_found && w_ready[w_probe]) begin
        w_rr_found = 1'b1;
        w_rr_id    = w_probe;
      end
    end
  end

  always_comb begin
    w_free_id = '0;
    for (int i = NumWarps - 1; i >= 0; i--) begin
      if (w_inactive[i]) w_free_id = WidWidth'(i);
    end
  end

  assign w_sel_id       = r_lock ? r_lock_id : w_rr_id;
  assign fe_valid_o     = r_lock | w_rr_found;
  assign fe_warp_id_o   = w_sel_id;
  assign fe_pc_o        = r_pc[w_sel_id];
  assign fe_act_mask_o  = r_mask[w_sel_id];
  assign launch_ready_o = |w_inactive;
  assign busy_o         = ~&w_inactive;

  assign w_fire   = fe_valid_o & ic_ready_i;
  assign w_launch = launch_valid_i & launch_ready_o;
  assign w_dec    = dec_decoded_i & (r_state[dec_decoded_warp_id_i] == ST_WAITING);

  // Fetch, decode and launch each act on a warp in a different state, so they never collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWarps; i++) begin
        r_state[i] <= ST_INACTIVE;
        r_pc[i]    <= '0;
        r_mask[i]  <= '0;
      end
      r_last    <= WidWidth'(NumWarps - 1);
      r_lock    <= 1'b0;
      r_lock_id <= '0;
    end else begin
      if (w_fire) begin
        r_state[w_sel_id] <= ST_WAITING;
        r_last            <= w_sel_id;
        r_lock            <= 1'b0;
      end else if (fe_valid_o) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_sel_id;
      end
      if (w_dec) begin
        if (dec_stop_warp_i) begin
          r_state[dec_decoded_warp_id_i] <= ST_INACTIVE;
        end else begin
          r_state[dec_decoded_warp_id_i] <= ST_READY;
          r_pc[dec_decoded_warp_id_i]    <= dec_decoded_next_pc_i;
        end
      end
      if (w_launch) begin
        r_state[w_free_id] <= ST_READY;
        r_pc[w_free_id]    <= launch_pc_i;
        r_mask[w_free_id]  <= launch_act_mask_i;
      end
    end
  end

`ifdef WARP_FETCH_PERF_COUNTER_EN
  logic [31:0] r_fetch_count;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_fetch_count <= '0;
    else if (w_fire) r_fetch_count <= r_fetch_count + 32'd1;
  end
  assign fetch_count_o = r_fetch_count;
`else
  assign fetch_count_o = 32'd0;
`endif

`ifndef SYNTHESIS
  a_dec_on_waiting: assert property (@(posedge clk_i) disable iff (rst_i)
    dec_decoded_i |-> (r_state[dec_decoded_warp_id_i] == ST_WAITING));
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Bench for warp_fetch_scheduler: directed scenarios plus random traffic against a per-warp state model.
module tb_warp_fetch_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        launch_valid;
  logic        launch_ready;
  logic [31:0] launch_pc;
  logic [31:0] launch_mask;
  logic        ic_ready;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_mask;
  logic [2:0]  fe_id;
  logic        dec;
  logic        dec_stop;
  logic [2:0]  dec_id;
  logic [31:0] dec_next_pc;
  logic        busy;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  warp_fetch_scheduler dut (
    .clk_i(clk), .rst_i(rst),
    .launch_valid_i(launch_valid), .launch_ready_o(launch_ready),
    .launch_pc_i(launch_pc), .launch_act_mask_i(launch_mask),
    .ic_ready_i(ic_ready),
    .fe_valid_o(fe_valid), .fe_pc_o(fe_pc), .fe_act_mask_o(fe_mask), .fe_warp_id_o(fe_id),
    .dec_decoded_i(dec), .dec_stop_warp_i(dec_stop),
    .dec_decoded_warp_id_i(dec_id), .dec_decoded_next_pc_i(dec_next_pc),
    .busy_o(busy), .fetch_count_o(fetch_count)
  );

  always #5 clk = ~clk;

  // Model: 0 = inactive, 1 = ready, 2 = waiting
  int          m_state [8];
  logic [31:0] m_pc    [8];
  logic [31:0] m_mask  [8];
  logic [2:0]  m_last;
  logic        m_lock;
  logic [2:0]  m_lock_id;
  logic [31:0] m_count;

  logic        e_valid;
  logic [2:0]  e_id;
  logic [31:0] e_pc;
  logic [31:0] e_mask;
  logic        e_lready;
  logic        e_busy;
  logic [31:0] e_count;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_state[i] = 0; m_pc[i] = 0; m_mask[i] = 0;
    end
    m_last = 3'd7; m_lock = 0; m_lock_id = 0; m_count = 0;
  endfunction

  function automatic void calc_expect();
    e_valid = 0; e_id = 0; e_lready = 0; e_busy = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_state[i] == 0) e_lready = 1; else e_busy = 1;
    end
    if (m_lock) begin
      e_valid = 1; e_id = m_lock_id;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int idx;
        idx = (int'(m_last) + k) % 8;
        if (!e_valid && m_state[idx] == 1) begin
          e_valid = 1; e_id = idx[2:0];
        end
      end
    end
    e_pc = m_pc[e_id];
    e_mask = m_mask[e_id];
`ifdef WARP_FETCH_PERF_COUNTER_EN
    e_count = m_count;
`else
    e_count = 32'd0;
`endif
  endfunction

  // Advance model by the rules using the current inputs, then clock the DUT.
  task automatic tick();
    int li;
    calc_expect();
    if (rst) begin
      model_reset();
    end else begin
      li = -1;
      if (launch_valid) begin
        for (int i = 7; i >= 0; i--) if (m_state[i] == 0) li = i;
      end
      if (e_valid && ic_ready) begin
        m_state[e_id] = 2; m_last = e_id; m_lock = 0; m_count = m_count + 1;
      end else if (e_valid) begin
        m_lock = 1; m_lock_id = e_id;
      end
      if (dec && m_state[dec_id] == 2) begin
        if (dec_stop) m_state[dec_id] = 0;
        else begin m_state[dec_id] = 1; m_pc[dec_id] = dec_next_pc; end
      end
      if (li >= 0) begin
        m_state[li] = 1; m_pc[li] = launch_pc; m_mask[li] = launch_mask;
      end
    end
    @(posedge clk);
    #1;
    calc_expect();
  endtask

  task automatic idle_inputs();
    launch_valid = 0; launch_pc = 0; launch_mask = 0; ic_ready = 0;
    dec = 0; dec_stop = 0; dec_id = 0; dec_next_pc = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); tick(); tick(); rst = 0;
    checks++;
    if (fe_valid !== 1'b0 || fe_pc !== 32'd0 || fe_mask !== 32'd0 || fe_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_fetch: got valid=%0b pc=%h mask=%h id=%0d want 0/0/0/0", fe_valid, fe_pc, fe_mask, fe_id);
    end
    checks++;
    if (launch_ready !== 1'b1 || busy !== 1'b0 || fetch_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_status: got lready=%0b busy=%0b count=%0d want 1/0/0", launch_ready, busy, fetch_count);
    end
  endtask

  task automatic test_launch_first();
    do_reset();
    launch_valid = 1; launch_pc = 32'h100; launch_mask = 32'hFFFF_FFFF;
    tick();
    launch_valid = 0;
    checks++;
    if (fe_valid !== 1'b1 || fe_id !== 3'd0 || fe_pc !== 32'h100 || fe_mask !== 32'hFFFF_FFFF || launch_ready !== 1'b1) begin
      errors++;
      $display("FAIL launch_first: got valid=%0b id=%0d pc=%h mask=%h lready=%0b want 1/0/100/ffffffff/1",
               fe_valid, fe_id, fe_pc, fe_mask, launch_ready);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      launch_valid = 1; launch_pc = 32'h400 + 32'(i * 16); launch_mask = 32'(i + 1);
      tick();
    end
    launch_valid = 0; ic_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fe_valid !== 1'b1 || fe_id !== 3'(i) || fe_pc !== 32'h400 + 32'(i * 16)) begin
        errors++;
        $display("FAIL rr_seq%0d: got valid=%0b id=%0d pc=%h want 1/%0d/%h", i, fe_valid, fe_id, fe_pc, i, 32'h400 + 32'(i * 16));
      end
      tick();
    end
    ic_ready = 0;
    checks++;
    if (fe_valid !== 1'b0 || busy !== 1'b1 || launch_ready !== 1'b1) begin
      errors++;
      $display("FAIL rr_drained: got valid=%0b busy=%0b lready=%0b want 0/1/1", fe_valid, busy, launch_ready);
    end
  endtask

  task automatic test_refetch();
    do_reset();
    launch_valid = 1; launch_pc = 32'h100; launch_mask = 32'h0000_00FF;
    tick();
    launch_valid = 0; ic_ready = 1;
    tick();
    ic_ready = 0;
    checks++;
    if (fe_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL refetch_waiting: got valid=%0b busy=%0b want 0/1", fe_valid, busy);
    end
    dec = 1; dec_id = 0; dec_stop = 0; dec_next_pc = 32'h101;
    tick();
    dec = 0;
    checks++;
    if (fe_valid !== 1'b1 || fe_id !== 3'd0 || fe_pc !== 32'h101 || fe_mask !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL refetch_pc: got valid=%0b id=%0d pc=%h mask=%h want 1/0/101/ff", fe_valid, fe_id, fe_pc, fe_mask);
    end
    ic_ready = 1;
    tick();
    ic_ready = 0; dec = 1; dec_id = 0; dec_stop = 1;
    tick();
    dec = 0; dec_stop = 0;
    checks++;
    if (busy !== 1'b0 || launch_ready !== 1'b1 || fe_valid !== 1'b0) begin
      errors++;
      $display("FAIL refetch_stop: got busy=%0b lready=%0b valid=%0b want 0/1/0", busy, launch_ready, fe_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      launch_valid = 1; launch_pc = 32'h200 + 32'(i * 16); launch_mask = 32'hA0 + 32'(i);
      tick();
    end
    launch_valid = 0; ic_ready = 1;
    tick(); tick();
    ic_ready = 0; dec = 1; dec_id = 0; dec_stop = 1;
    tick();
    dec = 0; dec_stop = 0;
    launch_valid = 1; launch_pc = 32'h300; launch_mask = 32'h1;
    tick();
    launch_valid = 0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (fe_valid !== 1'b1 || fe_id !== 3'd2 || fe_pc !== 32'h220 || fe_mask !== 32'hA2) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%0b id=%0d pc=%h mask=%h want 1/2/220/a2", c, fe_valid, fe_id, fe_pc, fe_mask);
      end
      tick();
    end
    ic_ready = 1;
    tick();
    checks++;
    if (fe_valid !== 1'b1 || fe_id !== 3'd0 || fe_pc !== 32'h300) begin
      errors++;
      $display("FAIL stall_next: got valid=%0b id=%0d pc=%h want 1/0/300", fe_valid, fe_id, fe_pc);
    end
    tick();
    ic_ready = 0; dec = 1; dec_id = 2; dec_next_pc = 32'h222;
    tick();
    dec_id = 1; dec_next_pc = 32'h212;
    tick();
    dec = 0;
    checks++;
    if (fe_valid !== 1'b1 || fe_id !== 3'd2 || fe_pc !== 32'h222) begin
      errors++;
      $display("FAIL lock_over_rr: got valid=%0b id=%0d pc=%h want 1/2/222", fe_valid, fe_id, fe_pc);
    end
    ic_ready = 1;
    tick();
    ic_ready = 0;
    checks++;
    if (fe_valid !== 1'b1 || fe_id !== 3'd1 || fe_pc !== 32'h212) begin
      errors++;
      $display("FAIL lock_release: got valid=%0b id=%0d pc=%h want 1/1/212", fe_valid, fe_id, fe_pc);
    end
  endtask

  task automatic test_full();
    do_reset();
    ic_ready = 1;
    for (int i = 0; i < 8; i++) begin
      launch_valid = 1; launch_pc = 32'h1000 + 32'(i * 4); launch_mask = 32'(1 << i);
      tick();
    end
    launch_valid = 0;
    checks++;
    if (launch_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_ready: got lready=%0b busy=%0b want 0/1", launch_ready, busy);
    end
    tick();
    ic_ready = 0;
    launch_valid = 1; launch_pc = 32'h555; launch_mask = 32'h55;
    dec = 1; dec_id = 5; dec_stop = 1;
    tick();
    dec = 0; dec_stop = 0;
    checks++;
    if (launch_ready !== 1'b1 || fe_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_stop_free: got lready=%0b valid=%0b want 1/0", launch_ready, fe_valid);
    end
    tick();
    launch_valid = 0;
    checks++;
    if (fe_valid !== 1'b1 || fe_id !== 3'd5 || fe_pc !== 32'h555 || fe_mask !== 32'h55 || launch_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_relaunch: got valid=%0b id=%0d pc=%h mask=%h lready=%0b want 1/5/555/55/0",
               fe_valid, fe_id, fe_pc, fe_mask, launch_ready);
    end
  endtask

  task automatic test_perf_reset();
    logic [31:0] want;
`ifdef WARP_FETCH_PERF_COUNTER_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    do_reset();
    launch_valid = 1; launch_pc = 32'h40; launch_mask = 32'hF;
    tick();
    launch_valid = 0;
    for (int i = 0; i < 10; i++) begin
      ic_ready = 1; tick();
      ic_ready = 0; dec = 1; dec_id = 0; dec_stop = 0; dec_next_pc = 32'h41 + 32'(i);
      tick();
      dec = 0;
    end
    checks++;
    if (fetch_count !== want) begin
      errors++;
      $display("FAIL perf_count: got %0d want %0d", fetch_count, want);
    end
    rst = 1; tick(); rst = 0;
    checks++;
    if (fetch_count !== 32'd0 || fe_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL perf_reset: got count=%0d valid=%0b busy=%0b want 0/0/0", fetch_count, fe_valid, busy);
    end
  endtask

  task automatic test_random();
    int nwait;
    int pick;
    int wlist [8];
    do_reset();
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (fe_valid !== e_valid || launch_ready !== e_lready || busy !== e_busy || fetch_count !== e_count ||
          (e_valid && (fe_id !== e_id || fe_pc !== e_pc || fe_mask !== e_mask))) begin
        errors++;
        $display("FAIL random_c%0d: got v=%0b id=%0d pc=%h m=%h lr=%0b b=%0b n=%0d want v=%0b id=%0d pc=%h m=%h lr=%0b b=%0b n=%0d",
                 c, fe_valid, fe_id, fe_pc, fe_mask, launch_ready, busy, fetch_count,
                 e_valid, e_id, e_pc, e_mask, e_lready, e_busy, e_count);
      end
      rst = ($urandom_range(0, 99) == 0);
      launch_valid = ($urandom_range(0, 1) == 1);
      launch_pc = $urandom;
      launch_mask = $urandom;
      ic_ready = ($urandom_range(0, 9) < 6);
      nwait = 0;
      for (int i = 0; i < 8; i++) if (m_state[i] == 2) begin wlist[nwait] = i; nwait++; end
      dec = 0; dec_stop = 0; dec_id = 0; dec_next_pc = 0;
      if (!rst && nwait > 0 && $urandom_range(0, 1) == 1) begin
        pick = wlist[$urandom_range(0, nwait - 1)];
        dec = 1; dec_id = pick[2:0];
        dec_stop = ($urandom_range(0, 9) < 3);
        dec_next_pc = $urandom;
      end
      tick();
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_launch_first();
    test_round_robin();
    test_refetch();
    test_stall();
    test_full();
    test_perf_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
